// File: rtl/fifo_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Package     : fifo_tx_pkg
// Description : Shared width, state encoding and parity helper for the
//               FIFO-draining UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package fifo_tx_pkg;

    localparam int DATA_W = 8;

    // Fixed 3-bit state codes; the enum below is built on top of them so the
    // encoding stays stable for anything that decodes the raw state value.
    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_req    = 3'd1;
    localparam logic [2:0] c_st_load   = 3'd2;
    localparam logic [2:0] c_st_start  = 3'd3;
    localparam logic [2:0] c_st_data   = 3'd4;
    localparam logic [2:0] c_st_parity = 3'd5;
    localparam logic [2:0] c_st_stop   = 3'd6;

    // PARITY is always part of the encoding; it is simply never entered when
    // the parity feature is compiled out.
    typedef enum logic [2:0] {
        IDLE   = c_st_idle,
        REQ    = c_st_req,
        LOAD   = c_st_load,
        START  = c_st_start,
        DATA   = c_st_data,
        PARITY = c_st_parity,
        STOP   = c_st_stop
    } tx_state_e;

    // Even parity: the parity bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

endpackage : fifo_tx_pkg
`default_nettype wire

// File: rtl/fifo_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Interface   : fifo_uart_tx_if
// Description : FIFO read port between the 8x8 FIFO and its serial drain.
//               master = the reader (owns rd_en), slave = the FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
interface fifo_uart_tx_if;
    import fifo_tx_pkg::*;

    logic              empty;
    logic [DATA_W-1:0] D_out;
    logic              rd_en;

    modport master (
        input  empty,
        input  D_out,
        output rd_en
    );

    modport slave (
        output empty,
        output D_out,
        input  rd_en
    );

endinterface : fifo_uart_tx_if
`default_nettype wire

// File: rtl/fifo_uart_tx_baud_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : baud_tick_gen
// Description : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and flags the
//               final cycle of a bit with tick. clr forces the count to zero
//               on the next edge (used at bit boundaries and while not
//               transmitting).
// Revision    : 1.0 - initial release
// ============================================================================
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic                              clk,
    input  wire logic                              rst,
    input  wire logic                              clr,
    output logic                                   tick,
    output logic [$clog2(CLKS_PER_BIT)-1:0]        count
);

    localparam int                CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  c_last_cnt = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] cnt_q;

    // Next count: restart on clear, otherwise advance by one.
    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr) begin
            cnt_d = '0;
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick  = (cnt_q == c_last_cnt);
    assign count = cnt_q;

endmodule : baud_tick_gen
`default_nettype wire

// File: rtl/fifo_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : fifo_uart_tx
// Description : Drains the 8-deep FIFO one byte at a time and sends each byte
//               as a UART frame: start, 8 data bits LSB first, optional even
//               parity, one stop bit. Sole owner of the FIFO rd_en.
//               Optional feature macro: FIFO_TX_PARITY_EN (adds parity bit).
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_uart_tx
    import fifo_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  wire logic            clk,
    input  wire logic            rst,
    fifo_uart_tx_if.master       bus,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done
);

    localparam int               CNT_W          = $clog2(CLKS_PER_BIT);
    // frame_done is registered, so it is set up one cycle before the final
    // stop-bit cycle, i.e. when the count sits one below its terminal value.
    localparam logic [CNT_W-1:0] c_pre_last_cnt = CNT_W'(CLKS_PER_BIT - 2);

    tx_state_e          state_d,      state_q;
    logic [DATA_W-1:0]  shreg_d,      shreg_q;
    logic [2:0]         bit_idx_d,    bit_idx_q;
    logic               tx_d,         tx_q;
    logic               busy_d,       busy_q;
    logic               frame_done_d, frame_done_q;
`ifdef FIFO_TX_PARITY_EN
    logic               parity_d,     parity_q;
`endif

    logic               w_baud_tick;
    logic               w_baud_clr;
    logic [CNT_W-1:0]   w_baud_cnt;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clr   (w_baud_clr),
        .tick  (w_baud_tick),
        .count (w_baud_cnt)
    );

    // Frame sequencing: next state, shift register, bit index, counter clear.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        w_baud_clr = 1'b1;
        case (state_q)
            IDLE: begin
                if (!bus.empty) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = LOAD;
            end
            LOAD: begin
                shreg_d = bus.D_out;
                state_d = START;
            end
            START: begin
                w_baud_clr = w_baud_tick;
                if (w_baud_tick) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                w_baud_clr = w_baud_tick;
                if (w_baud_tick) begin
                    shreg_d   = shreg_q >> 1;
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
`ifdef FIFO_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef FIFO_TX_PARITY_EN
            PARITY: begin
                w_baud_clr = w_baud_tick;
                if (w_baud_tick) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                w_baud_clr = w_baud_tick;
                if (w_baud_tick) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef FIFO_TX_PARITY_EN
    // Parity of the byte is latched together with the byte itself, since the
    // shift register no longer holds the data by the time PARITY is sent.
    always_comb begin
        parity_d = parity_q;
        if (state_q == LOAD) begin
            parity_d = even_parity(bus.D_out);
        end
    end
`endif

    // Registered outputs are derived from next-state values so tx, busy and
    // frame_done line up with the state they describe.
    always_comb begin
        tx_d = 1'b1;
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shreg_d[0];
`ifdef FIFO_TX_PARITY_EN
            PARITY:  tx_d = parity_q;
`endif
            default: tx_d = 1'b1;
        endcase
        busy_d       = (state_d != IDLE);
        frame_done_d = (state_q == STOP) && (w_baud_cnt == c_pre_last_cnt);
    end

    // State and output registers; reset abandons any frame in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            shreg_q      <= '0;
            bit_idx_q    <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef FIFO_TX_PARITY_EN
            parity_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            shreg_q      <= shreg_d;
            bit_idx_q    <= bit_idx_d;
            tx_q         <= tx_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
`ifdef FIFO_TX_PARITY_EN
            parity_q     <= parity_d;
`endif
        end
    end

    // Pop strobe is a pure decode of REQ, which is only entered when the
    // FIFO reported non-empty.
    assign bus.rd_en  = (state_q == REQ);
    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule : fifo_uart_tx
`default_nettype wire
